// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle multiply/divide unit for the execute stage.
// Iterative radix-2 shift-add multiply and restoring divide over operand
// magnitudes, with sign fix-up on entry to DONE. Optional single-cycle multiply.
module exe_muldiv #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dz_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {0, dividend/quotient}
  logic [WIDTH-1:0]     a_q, a_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;

  logic                 accept, s1_neg, s2_neg;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   fast_prod, mul_next, prod_fix;
  logic [WIDTH:0]       mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]     quot_step, rem_step;

  // Operand conditioning and one iteration of each datapath.
  always_comb begin
    accept    = (state_q == S_IDLE) & start_i & ~cancel_i;
    s1_neg    = ~op_i[0] & src1_i[WIDTH-1];
    s2_neg    = ~op_i[0] & src2_i[WIDTH-1];
    mag1      = s1_neg ? -src1_i : src1_i;
    mag2      = s2_neg ? -src2_i : src2_i;
    fast_prod = {{WIDTH{s1_neg}}, src1_i} * {{WIDTH{s2_neg}}, src2_i};

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix  = neg_res_q ? -mul_next : mul_next;

    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, a_q};
    if (!div_trial[WIDTH]) begin
      rem_step  = div_trial[WIDTH-1:0];
      quot_step = {acc_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step  = div_shift[WIDTH-1:0];
      quot_step = {acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_div_d  = op_i[1];
          neg_res_d = s1_neg ^ s2_neg;
          neg_rem_d = s1_neg;
          rem_d     = '0;
          cnt_d     = CW'(WIDTH);
          state_d   = S_BUSY;
          if (!op_i[1]) begin
            a_d   = mag1;
            acc_d = {{WIDTH{1'b0}}, mag2};
            if (FAST_MUL != 0) begin
              {hi_d, lo_d} = fast_prod;
              dz_d         = 1'b0;
              state_d      = S_DONE;
            end
          end else begin
            a_d   = mag2;
            acc_d = {{WIDTH{1'b0}}, mag1};
            if (src2_i == '0) begin
              hi_d    = src1_i;
              lo_d    = '1;
              dz_d    = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_BUSY: begin
        if (cancel_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], quot_step};
            rem_d = rem_step;
          end else begin
            acc_d = mul_next;
          end
          // Sign fix-up is folded into the final iteration so DONE shows the result.
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            dz_d    = 1'b0;
            if (is_div_q) begin
              lo_d = neg_res_q ? -quot_step : quot_step;
              hi_d = neg_rem_q ? -rem_step : rem_step;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign stall_o = accept | (state_q == S_BUSY);
  assign busy_o  = (state_q == S_BUSY);
  assign valid_o = (state_q == S_DONE);
  assign dz_o    = valid_o & dz_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: doc/exe_muldiv.md
# exe_muldiv

Parametrised multi-cycle multiply/divide unit for the execute stage. It accepts MULT/MULTU/DIV/DIVU operands from the execute stage and produces a double-width {HI, LO} result. It holds the pipeline through a stall output while iterating, and returns the result with a one-cycle valid pulse for the HI/LO write path. Compared with a single-cycle multiply, it adds division, iterative shift-add/restoring datapaths, an optional single-cycle multiply mode, cancellation, and divide-by-zero reporting.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- FAST_MUL, 0: 1 = multiply completes in one cycle (single registered `*`); 0 = iterative multiply, same latency as divide.
- cpu_clk_50M  in  1  clock; all state updates on the rising edge.
- cpu_rst  in  1  reset; synchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src1_i  in  WIDTH  multiplicand or dividend; captured at accept.
- src2_i  in  WIDTH  multiplier or divisor; captured at accept.
- cancel_i  in  1  flush; aborts any operation in progress.
- stall_o  out  1  pipeline hold request (combinational; see Operation).
- busy_o  out  1  state is BUSY.
- valid_o  out  1  one-cycle result strobe.
- hi_o  out  WIDTH  product upper half, or remainder.
- lo_o  out  WIDTH  product lower half, or quotient.
- dz_o  out  1  divide by zero; qualified by valid_o.

## Operation
- States are IDLE, BUSY and DONE.
- **Reset:** state = IDLE; valid_o, busy_o, dz_o, hi_o, lo_o, iteration counter and datapath registers all 0. Reset takes priority over every other input.
- **Accept:** IDLE & start_i & !cancel_i. Operands and op are latched.
  - Signed ops (MULT, DIV) latch operand magnitudes plus two sign bits.
  - Unsigned ops latch operands as-is.
- **Transitions from IDLE on accept:**
  - Multiply with FAST_MUL=1 → DONE.
  - Divide with src2_i = 0 → DONE, setting dz.
  - All other cases → BUSY with counter = WIDTH.
- **BUSY:** one iteration per cycle; counter decrements; when the counter reaches 1 and that iteration completes, go to DONE.
  - Multiply: radix-2 shift-add over a 2·WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle; WIDTH+1-bit partial remainder.
- **Sign fix-up** is applied on entry to DONE:
  - Product is negated (two's complement, 2·WIDTH bits) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- **DONE:** valid_o = 1 and hi_o/lo_o/dz_o hold the result for exactly this cycle; next state is IDLE. start_i is ignored in DONE.
- **Divide by zero:** hi_o = src1 (unmodified), lo_o = all ones, dz_o = 1.
- **Overflow (DIV of most-negative by −1):** lo_o = 0x8000_0000 (wraps, i.e. the most-negative value at WIDTH=32), hi_o = 0, dz_o = 0. No trap.
- **Cancel:**
  - In BUSY: next state IDLE, no valid_o, result discarded.
  - In IDLE: suppresses accept.
  - In DONE: valid_o still asserts; the pipeline is responsible for discarding it.
- **Outside DONE:** valid_o = 0. hi_o/lo_o retain their last value; dz_o = 0.
- **stall_o** = (IDLE & start_i & !cancel_i) | BUSY.
  - It is low in DONE so the held instruction advances together with the result.

## Timing
- Accept at edge T (the stall cycle is T−1→T, combinational on start_i).
- Iterative ops: BUSY for WIDTH cycles, DONE in cycle T+WIDTH, so valid_o is high in that cycle. At WIDTH=32, valid_o is high in cycle 33 counting the accept cycle as 0.
- FAST_MUL multiply, and divide by zero: DONE in the cycle after accept (latency 1).
- The earliest next accept is the cycle after DONE, so back-to-back issue costs one IDLE cycle.
- Cancel sampled at edge E in BUSY: busy_o = 0 and stall_o = 0 (absent start_i) from E onward.
- Reset asserted mid-BUSY: IDLE at the next edge; no valid_o is ever produced for the aborted op.

## Test plan
- **MULT (WIDTH=32, FAST_MUL=0):** src1 = 0xFFFF_FFFD (−3), src2 = 7 → valid_o exactly once, 33 cycles after accept; hi_o = 0xFFFF_FFFF, lo_o = 0xFFFF_FFEB. stall_o high for the 33 preceding cycles and low in the valid cycle.
- **MULTU, both FAST_MUL settings:** 0xFFFF_FFFF × 0xFFFF_FFFF → hi_o = 0xFFFF_FFFE, lo_o = 0x0000_0001. FAST_MUL=1 gives valid_o one cycle after accept.
- **Signed divide:**
  - DIV −7 / 2 → lo_o = 0xFFFF_FFFD, hi_o = 0xFFFF_FFFF.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → lo_o = 0x8000_0000, hi_o = 0, dz_o = 0.
- **Divide by zero:** DIVU 100 / 0 → valid_o the cycle after accept; dz_o = 1, hi_o = 100, lo_o = 0xFFFF_FFFF.
- **Cancel:** DIV started, cancel_i pulsed 10 cycles after accept → busy_o low the next cycle, no valid_o. A new DIVU 100 / 7 issued afterwards → lo_o = 14, hi_o = 2.
- **Reset mid-operation:** cpu_rst pulsed mid-BUSY → all outputs 0 the next cycle, state IDLE. start_i held high during reset is not accepted.
